pulse_width_generator: RTL and testbench

Programmable pulse-train generator that drives a single-bit line high for a programmed number of cycles, then low for a programmed gap, for a programmed number of pulses. It is the transmit-side counterpart of the team's pulse-width measurement block. A programmed `width` value W produces a pulse that the measurement block reports as W, so both ends of a loopback test agree numerically. The generator sits on the stimulus side of the timing-measurement path and is driven by a control FSM or CSR bank through a start/busy/done handshake.

---
 rtl/pulse_gen_pkg.sv | 15 +
 rtl/pg_phase_counter.sv | 31 +++
 rtl/pulse_width_generator.sv | 131 +++++++++++++
 tb/tb_pulse_width_generator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse generator and its measurement counterpart.
// Combinational definitions only; no latency, no flow control.
// No backpressure; constants and the FSM state type are consumed by importers.
package pulse_gen_pkg;

    localparam int PG_CNT_W = 32;
    localparam int PG_NUM_W = 16;

    typedef enum logic [1:0] {
        PG_IDLE = 2'd0,
        PG_HIGH = 2'd1,
        PG_LOW  = 2'd2
    } pg_state_t;

endpackage

// File: rtl/pg_phase_counter.sv
// Loadable down-counter with zero flag, shared by the high and low phases.
// Load/decrement take effect on the next edge; zero is combinational from the count.
// No backpressure; decrement saturates at zero.
module pg_phase_counter
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = PG_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_width_generator.sv
// Programmable pulse-train generator (width+1 high, gap+1 low, num_pulses times); macro PULSE_WIDTH_GENERATOR_CONTINUOUS_EN makes num_pulses=0 run until abort.
// pulse_out rises on the edge that accepts start; done strobes the cycle after the final high phase.
// start is ignored while busy; abort wins over everything and returns to idle on the next edge.
module pulse_width_generator
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = PG_CNT_W,
    parameter int NUM_W = PG_NUM_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulses_sent
);

    pg_state_t        state, state_nx;
    logic [CNT_W-1:0] width_lat, gap_lat, cnt_load_val;
    logic [NUM_W-1:0] num_lat, num_eff, sent_inc, sent_nx;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             latch, last, pulse_nx, done_nx;

    pg_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign sent_inc = pulses_sent + NUM_W'(1);

`ifdef PULSE_WIDTH_GENERATOR_CONTINUOUS_EN
    // A latched count of zero never matches, so the train runs until abort.
    assign num_eff = num_pulses;
    assign last    = (sent_inc == num_lat) && (num_lat != '0);
`else
    assign num_eff = (num_pulses == '0) ? NUM_W'(1) : num_pulses;
    assign last    = (sent_inc == num_lat);
`endif

    assign busy = (state != PG_IDLE);

    always_comb begin
        state_nx     = state;
        pulse_nx     = pulse_out;
        done_nx      = 1'b0;
        sent_nx      = pulses_sent;
        cnt_load     = 1'b0;
        cnt_load_val = width_lat;
        cnt_dec      = 1'b0;
        latch        = 1'b0;
        if (abort) begin
            state_nx = PG_IDLE;
            pulse_nx = 1'b0;
        end else begin
            case (state)
                PG_IDLE: begin
                    pulse_nx = 1'b0;
                    if (start) begin
                        latch        = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = width;
                        sent_nx      = '0;
                        state_nx     = PG_HIGH;
                        pulse_nx     = 1'b1;
                    end
                end
                PG_HIGH: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        sent_nx  = sent_inc;
                        pulse_nx = 1'b0;
                        if (last) begin
                            state_nx = PG_IDLE;
                            done_nx  = 1'b1;
                        end else begin
                            cnt_load     = 1'b1;
                            cnt_load_val = gap_lat;
                            state_nx     = PG_LOW;
                        end
                    end
                end
                PG_LOW: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                        state_nx = PG_HIGH;
                        pulse_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx = PG_IDLE;
                    pulse_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PG_IDLE;
            pulse_out   <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
            width_lat   <= '0;
            gap_lat     <= '0;
            num_lat     <= '0;
        end else begin
            state       <= state_nx;
            pulse_out   <= pulse_nx;
            done        <= done_nx;
            pulses_sent <= sent_nx;
            if (latch) begin
                width_lat <= width;
                gap_lat   <= gap;
                num_lat   <= num_eff;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_generator.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and randomized jobs vs an arithmetic waveform model.
module tb_pulse_width_generator;
    localparam int CW = 4;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] width = '0;
    logic [CW-1:0] gap = '0;
    logic [NW-1:0] num_pulses = '0;
    logic          pulse_out, busy, done;
    logic [NW-1:0] pulses_sent;

    int checks = 0;
    int errors = 0;

    pulse_width_generator #(.CNT_W(CW), .NUM_W(NW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .width       (width),
        .gap         (gap),
        .num_pulses  (num_pulses),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Completed high phases seen by cycle t of a job (t=0 is the first high cycle).
    function automatic int model_sent(int t, int w, int g);
        if (t < w + 1) return 0;
        return (t - w - 1) / (w + g + 2) + 1;
    endfunction

    function automatic int model_pulse(int t, int w, int g);
        return ((t % (w + g + 2)) <= w) ? 1 : 0;
    endfunction

    // Starts a job and follows it to its done cycle (or the cycle after abort) without stepping past it.
    task automatic run_job(input int w, input int g, input int n, input int abort_at,
                           output int busy_cnt, output int hi_len, output int sent_fin);
        int nn, total;
        bit in_first;
        nn = (n == 0) ? 1 : n;
        total = nn * (w + 1) + (nn - 1) * (g + 1);
        busy_cnt = 0; hi_len = 0; in_first = 1'b1; sent_fin = -1;
        start = 1'b1; abort = 1'b0;
        width = CW'(w); gap = CW'(g); num_pulses = NW'(n);
        step();
        for (int t = 0; t <= total; t++) begin
            if (busy) busy_cnt++;
            if (in_first && pulse_out) hi_len++;
            else in_first = 1'b0;
            if (abort_at >= 0 && t == abort_at + 1) begin
                chk("abort_pulse", pulse_out, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_sent", pulses_sent, model_sent(abort_at, w, g));
                sent_fin = pulses_sent;
                break;
            end
            if (t == total) begin
                chk("end_pulse", pulse_out, 0);
                chk("end_busy", busy, 0);
                chk("end_done", done, 1);
                chk("end_sent", pulses_sent, nn);
                sent_fin = pulses_sent;
                break;
            end
            chk("run_pulse", pulse_out, model_pulse(t, w, g));
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_sent", pulses_sent, model_sent(t, w, g));
            // Noise on start and fields while busy must not disturb the job.
            start = (t < total - 1) ? 1'($urandom) : 1'b0;
            width = CW'($urandom); gap = CW'($urandom); num_pulses = NW'($urandom);
            abort = (t == abort_at);
            step();
        end
        start = 1'b0; abort = 1'b0;
    endtask

    typedef struct {
        int w; int g; int n; int ab;
        int exp_busy; int exp_sent; int exp_hi;
    } vec_t;

    vec_t vt[5];
    int bc, hl, sf;

    initial begin
        vt[0] = '{w: 4,  g: 2, n: 1, ab: -1, exp_busy: 5,  exp_sent: 1, exp_hi: 5};
        vt[1] = '{w: 0,  g: 0, n: 3, ab: -1, exp_busy: 5,  exp_sent: 3, exp_hi: 1};
        vt[2] = '{w: 10, g: 3, n: 2, ab: 3,  exp_busy: 4,  exp_sent: 0, exp_hi: 4};
        vt[3] = '{w: 15, g: 0, n: 1, ab: -1, exp_busy: 16, exp_sent: 1, exp_hi: 16};
        vt[4] = '{w: 2,  g: 3, n: 2, ab: -1, exp_busy: 10, exp_sent: 2, exp_hi: 3};

        #1;
        chk("rst_pulse", pulse_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", pulses_sent, 0);
        step(); step();
        reset_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            run_job(vt[i].w, vt[i].g, vt[i].n, vt[i].ab, bc, hl, sf);
            chk("vec_busy_cycles", bc, vt[i].exp_busy);
            chk("vec_sent", sf, vt[i].exp_sent);
            chk("vec_first_high", hl, vt[i].exp_hi);
            step();
        end

        // Back-to-back: start on the done cycle, exactly one low cycle between jobs.
        run_job(1, 1, 2, -1, bc, hl, sf);
        run_job(0, 2, 1, -1, bc, hl, sf);
        chk("b2b_busy_cycles", bc, 1);
        step();

        // Simultaneous start and abort in idle: nothing starts, count holds.
        start = 1'b1; abort = 1'b1; width = 4'd3; num_pulses = 16'd1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_pulse", pulse_out, 0);
        chk("sa_sent_hold", pulses_sent, 1);
        step();

`ifdef PULSE_WIDTH_GENERATOR_CONTINUOUS_EN
        start = 1'b1; width = 4'd1; gap = 4'd1; num_pulses = '0;
        step();
        start = 1'b0;
        for (int t = 0; t < 99; t++) begin
            if (done) chk("cont_no_done", done, 0);
            step();
        end
        chk("cont_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("cont_stop_busy", busy, 0);
        chk("cont_stop_done", done, 0);
        chk("cont_sent", pulses_sent, 25);
        step();
`else
        run_job(2, 1, 0, -1, bc, hl, sf);
        chk("zero_count_sent", sf, 1);
        chk("zero_count_high", hl, 3);
        step();
`endif

        // Asynchronous reset in the middle of a low phase.
        start = 1'b1; width = 4'd2; gap = 4'd6; num_pulses = 16'd3;
        step();
        start = 1'b0;
        for (int t = 0; t < 5; t++) step();
        chk("pre_rst_low", pulse_out, 0);
        chk("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_pulse", pulse_out, 0);
        chk("arst_done", done, 0);
        chk("arst_sent", pulses_sent, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);

        for (int j = 0; j < 30; j++) begin
            int w, g, n, nn, total, ab;
            w = $urandom_range(0, 6);
            g = $urandom_range(0, 6);
`ifdef PULSE_WIDTH_GENERATOR_CONTINUOUS_EN
            n = $urandom_range(1, 4);
`else
            n = $urandom_range(0, 4);
`endif
            nn = (n == 0) ? 1 : n;
            total = nn * (w + 1) + (nn - 1) * (g + 1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total - 1) : -1;
            run_job(w, g, n, ab, bc, hl, sf);
            if ($urandom_range(0, 1) == 0) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
